// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: pops one word per cycle from four source fifos and routes it
// to one of four destination fifos selected by the word's top two bits.
// Pop-to-write latency is two cycles, and new pops stop while any destination is almost full.
// Optional build macro ARB_STRICT_PRIO_EN selects fixed priority (src 0 highest)
// instead of the default round-robin grant.
module fifo_rr_arbiter #(
    parameter int DATA_W = 6,
    parameter int N_SRC  = 4
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [N_SRC-1:0]        src_empty,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_rd,
    input  logic [N_SRC-1:0]        dst_almost_full,
    output logic [N_SRC-1:0]        dst_wr,
    output logic [DATA_W-1:0]       dst_data,
    output logic [1:0]              arb_state,
    output logic                    idle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2
    } arb_state_t;

    // Two-bit index to one-hot select.
    function automatic logic [3:0] dec_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

`ifdef ARB_STRICT_PRIO_EN
    // Fixed priority: lowest requesting index wins. Returns {valid, index}.
    function automatic logic [2:0] prio_pick(input logic [3:0] req);
        logic [2:0] res;
        if (req[0]) begin
            res = {1'b1, 2'd0};
        end else if (req[1]) begin
            res = {1'b1, 2'd1};
        end else if (req[2]) begin
            res = {1'b1, 2'd2};
        end else if (req[3]) begin
            res = {1'b1, 2'd3};
        end else begin
            res = {1'b0, 2'd0};
        end
        return res;
    endfunction
`else
    // Round robin: first request found after last, wrapping. Returns {valid, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] cand;
        res  = {1'b0, 2'd0};
        cand = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + k[1:0];
            if (!res[2] && req[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction
`endif

    logic              pause_s;
    logic [3:0]        req_s;
    logic              any_req_s;
    logic [2:0]        pick_s;
    logic              grant_vld_s;
    logic [1:0]        grant_idx_s;
    logic [DATA_W-1:0] word_s;

    logic              v1_r;
    logic [1:0]        sel1_r;
    logic              v2_r;
    logic [3:0]        dst_wr_r;
    logic [DATA_W-1:0] dst_data_r;
    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
`ifndef ARB_STRICT_PRIO_EN
    logic [1:0]        last_grant_r;
`endif

    assign pause_s   = |dst_almost_full;
    assign req_s     = ~src_empty;
    assign any_req_s = |req_s;
    assign word_s    = src_data[sel1_r*DATA_W +: DATA_W];

    // Grant selection; no pop during reset or while any destination is almost full.
    always_comb begin
        pick_s = {1'b0, 2'd0};
        if (!RESET && !pause_s) begin
`ifdef ARB_STRICT_PRIO_EN
            pick_s = prio_pick(req_s);
`else
            pick_s = rr_pick(req_s, last_grant_r);
`endif
        end else begin
            pick_s = {1'b0, 2'd0};
        end
    end

    assign grant_vld_s = pick_s[2];
    assign grant_idx_s = pick_s[1:0];

    // Read strobe to the granted source fifo.
    always_comb begin
        src_rd = 4'b0000;
        if (grant_vld_s) begin
            src_rd = dec_onehot(grant_idx_s);
        end else begin
            src_rd = 4'b0000;
        end
    end

`ifndef ARB_STRICT_PRIO_EN
    // Round-robin pointer: remembers the most recently granted source.
    always_ff @(posedge clk) begin
        if (RESET) begin
            last_grant_r <= 2'd3;
        end else if (grant_vld_s) begin
            last_grant_r <= grant_idx_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    // Stage 1: remembers which source was popped while its fifo presents the word.
    always_ff @(posedge clk) begin
        if (RESET) begin
            v1_r   <= 1'b0;
            sel1_r <= 2'd0;
        end else begin
            v1_r   <= grant_vld_s;
            sel1_r <= grant_vld_s ? grant_idx_s : sel1_r;
        end
    end

    // Stage 2: registers the word and pulses the write of the destination it names.
    always_ff @(posedge clk) begin
        if (RESET) begin
            v2_r       <= 1'b0;
            dst_wr_r   <= 4'b0000;
            dst_data_r <= {DATA_W{1'b0}};
        end else if (v1_r) begin
            v2_r       <= 1'b1;
            dst_wr_r   <= dec_onehot(word_s[DATA_W-1 -: 2]);
            dst_data_r <= word_s;
        end else begin
            v2_r       <= 1'b0;
            dst_wr_r   <= 4'b0000;
            dst_data_r <= dst_data_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s && !pause_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else if (any_req_s && pause_s) begin
                    state_nxt_s = ST_PAUSE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (pause_s && any_req_s) begin
                    state_nxt_s = ST_PAUSE;
                end else if (!any_req_s && !pause_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_PAUSE: begin
                if (!pause_s && any_req_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else if (!any_req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    assign dst_wr    = dst_wr_r;
    assign dst_data  = dst_data_r;
    assign arb_state = state_r;
    assign idle      = (state_r == ST_IDLE) && !v1_r && !v2_r;

endmodule
